// File: rtl/asu_ddr5_phase_serializer.sv
// -----------------------------------------------------------------------------
// asu_ddr5_phase_serializer
//
// Multi-lane DFI write-phase serializer. A whole multi-phase write group is
// accepted per handshake and buffered in a small FIFO. Phases are then emitted
// one per clock, oldest phase first, on all lanes in lockstep. Each group keeps
// its own phase count K, sampled from the frequency ratio when it is pushed.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          asynchronous reset, active high
//   enable_i       block enable; low freezes push, pop and the phase counter
//   freq_ratio_i   00=1:1 (K=1), 01=1:2 (K=2), 10=1:4 (K=4), 11=reserved (K=1)
//   in_valid_i     group valid
//   in_ready_o     group accepted on in_valid_i & in_ready_o at an edge
//   wrdata_en_i    per-phase write enable, bit k = phase k
//   wrdata_i       group data, phase-major then lane-major
//   wrdata_mask_i  group mask, same packing as wrdata_i
//   out_valid_o    a phase is being presented
//   wrdata_en_o    write enable of the presented phase
//   wrdata_o       data of the presented phase (all lanes)
//   wrdata_mask_o  mask of the presented phase (all lanes)
//   fifo_count_o   number of buffered groups not yet started
//   cfg_err_o      sticky flag: a group was pushed with the reserved ratio
// -----------------------------------------------------------------------------
module asu_ddr5_phase_serializer #(
  parameter int pDRAM_SIZE = 4,
  parameter int pNUM_LANE  = 2,
  parameter int pNUM_PHASE = 4,
  parameter int pDEPTH     = 4
) (
  input  logic                                           clk_i,
  input  logic                                           rst_i,
  input  logic                                           enable_i,
  input  logic [1:0]                                     freq_ratio_i,
  input  logic                                           in_valid_i,
  output logic                                           in_ready_o,
  input  logic [pNUM_PHASE-1:0]                          wrdata_en_i,
  input  logic [pNUM_PHASE*pNUM_LANE*2*pDRAM_SIZE-1:0]   wrdata_i,
  input  logic [pNUM_PHASE*pNUM_LANE*pDRAM_SIZE/4-1:0]   wrdata_mask_i,
  output logic                                           out_valid_o,
  output logic                                           wrdata_en_o,
  output logic [pNUM_LANE*2*pDRAM_SIZE-1:0]              wrdata_o,
  output logic [pNUM_LANE*pDRAM_SIZE/4-1:0]              wrdata_mask_o,
  output logic [$clog2(pDEPTH):0]                        fifo_count_o,
  output logic                                           cfg_err_o
);

  localparam int DW  = pNUM_LANE * 2 * pDRAM_SIZE;   // one phase, all lanes
  localparam int MW  = pNUM_LANE * pDRAM_SIZE / 4;
  localparam int AW  = $clog2(pDEPTH);
  localparam int CW  = AW + 1;
  localparam int PIW = (pNUM_PHASE > 1) ? $clog2(pNUM_PHASE) : 1;

  typedef enum logic {
    S_IDLE,   // no phases left to emit from a loaded entry
    S_SHIFT   // stepping the phase counter over the loaded entry
  } state_t;

  // Index of the last phase to emit (K-1) for a given ratio code.
  function automatic logic [PIW-1:0] last_phase(input logic [1:0] ratio);
    case (ratio)
      2'b01:   return PIW'(1);
      2'b10:   return PIW'(3);
      default: return '0;    // 1:1 and the reserved code both give K=1
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Group FIFO
  // ---------------------------------------------------------------------------
  logic [pNUM_PHASE*DW-1:0] mem_data [pDEPTH];
  logic [pNUM_PHASE*MW-1:0] mem_mask [pDEPTH];
  logic [pNUM_PHASE-1:0]    mem_en   [pDEPTH];
  logic [PIW-1:0]           mem_last [pDEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
  state_t        state;

  // Ready ignores a same-cycle pop on purpose: a full FIFO never bypasses.
  assign in_ready_o = enable_i & ~rst_i & (fifo_count_o < CW'(pDEPTH));
  assign push       = in_valid_i & in_ready_o;
  // An entry leaves the FIFO at the edge that presents its phase 0.
  assign pop        = enable_i & (state == S_IDLE) & (fifo_count_o != '0);

  // NOTE: storage carries no reset; pointers and count define which slots are
  // meaningful, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data[wr_ptr] <= wrdata_i;
      mem_mask[wr_ptr] <= wrdata_mask_i;
      mem_en[wr_ptr]   <= wrdata_en_i;
      mem_last[wr_ptr] <= last_phase(freq_ratio_i);
    end
  end

  // NOTE: every state register uses non-blocking assignment so that all
  // registers update from pre-edge values, independent of block order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count_o <= '0;
      cfg_err_o    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (freq_ratio_i == 2'b11) cfg_err_o <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count_o <= fifo_count_o + CW'(1);
        2'b01:   fifo_count_o <= fifo_count_o - CW'(1);
        default: fifo_count_o <= fifo_count_o;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Serializer: holds the entry being emitted; ph is the next phase to emit.
  // ---------------------------------------------------------------------------
  logic [pNUM_PHASE*DW-1:0] cur_data;
  logic [pNUM_PHASE*MW-1:0] cur_mask;
  logic [pNUM_PHASE-1:0]    cur_en;
  logic [PIW-1:0]           cur_last;
  logic [PIW-1:0]           ph;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      ph            <= '0;
      cur_data      <= '0;
      cur_mask      <= '0;
      cur_en        <= '0;
      cur_last      <= '0;
      out_valid_o   <= 1'b0;
      wrdata_en_o   <= 1'b0;
      wrdata_o      <= '0;
      wrdata_mask_o <= '0;
    end else begin
      // Idle outputs unless a phase is emitted below.
      out_valid_o   <= 1'b0;
      wrdata_en_o   <= 1'b0;
      wrdata_o      <= '0;
      wrdata_mask_o <= '0;
      if (enable_i) begin
        if (state == S_SHIFT) begin
          out_valid_o   <= 1'b1;
          wrdata_en_o   <= cur_en[ph];
          wrdata_o      <= cur_data[int'(ph)*DW +: DW];
          wrdata_mask_o <= cur_mask[int'(ph)*MW +: MW];
          ph            <= ph + PIW'(1);
          // After the last phase the next edge may load the following entry,
          // so consecutive groups stream without a bubble.
          if (ph == cur_last) state <= S_IDLE;
        end else if (pop) begin
          // Load and present phase 0 in the same edge.
          cur_data      <= mem_data[rd_ptr];
          cur_mask      <= mem_mask[rd_ptr];
          cur_en        <= mem_en[rd_ptr];
          cur_last      <= mem_last[rd_ptr];
          out_valid_o   <= 1'b1;
          wrdata_en_o   <= mem_en[rd_ptr][0];
          wrdata_o      <= mem_data[rd_ptr][DW-1:0];
          wrdata_mask_o <= mem_mask[rd_ptr][MW-1:0];
          ph            <= PIW'(1);
          state         <= (mem_last[rd_ptr] == '0) ? S_IDLE : S_SHIFT;
        end
      end
    end
  end

endmodule

// File: tb/tb_asu_ddr5_phase_serializer.sv
// -----------------------------------------------------------------------------
// tb_asu_ddr5_phase_serializer
//
// Self-checking bench. The reference model flattens every accepted group into
// its K phases on a queue; each enabled edge emits the queue head. Groups not
// yet started are counted to predict fifo_count_o and in_ready_o.
// -----------------------------------------------------------------------------
module tb_asu_ddr5_phase_serializer;

  localparam int N  = 4;
  localparam int L  = 2;
  localparam int PH = 4;
  localparam int D  = 4;
  localparam int DW = L * 2 * N;
  localparam int MW = L * N / 4;
  localparam int CW = $clog2(D) + 1;

  logic                 clk = 1'b0;
  logic                 rst_i = 1'b1;
  logic                 enable_i = 1'b0;
  logic [1:0]           freq_ratio_i = 2'b00;
  logic                 in_valid_i = 1'b0;
  logic                 in_ready_o;
  logic [PH-1:0]        wrdata_en_i = '0;
  logic [PH*DW-1:0]     wrdata_i = '0;
  logic [PH*MW-1:0]     wrdata_mask_i = '0;
  logic                 out_valid_o;
  logic                 wrdata_en_o;
  logic [DW-1:0]        wrdata_o;
  logic [MW-1:0]        wrdata_mask_o;
  logic [CW-1:0]        fifo_count_o;
  logic                 cfg_err_o;

  asu_ddr5_phase_serializer #(
    .pDRAM_SIZE (N),
    .pNUM_LANE  (L),
    .pNUM_PHASE (PH),
    .pDEPTH     (D)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .enable_i      (enable_i),
    .freq_ratio_i  (freq_ratio_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .wrdata_en_i   (wrdata_en_i),
    .wrdata_i      (wrdata_i),
    .wrdata_mask_i (wrdata_mask_i),
    .out_valid_o   (out_valid_o),
    .wrdata_en_o   (wrdata_en_o),
    .wrdata_o      (wrdata_o),
    .wrdata_mask_o (wrdata_mask_o),
    .fifo_count_o  (fifo_count_o),
    .cfg_err_o     (cfg_err_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [DW-1:0] d;
    logic [MW-1:0] m;
    logic          en;
    bit            first;
  } ph_t;

  ph_t           q[$];
  int            grp_pending = 0;
  bit            m_err = 0;
  logic          exp_valid = 0;
  logic          exp_en = 0;
  logic [DW-1:0] exp_d = '0;
  logic [MW-1:0] exp_m = '0;

  function automatic bit m_ready();
    return enable_i && !rst_i && (grp_pending < D);
  endfunction

  task automatic model_reset();
    q.delete();
    grp_pending = 0;
    m_err       = 0;
    exp_valid   = 0;
    exp_en      = 0;
    exp_d       = '0;
    exp_m       = '0;
  endtask

  task automatic model_edge();
    bit  acc;
    int  k;
    ph_t h;
    acc = in_valid_i && m_ready();
    if (enable_i && q.size() > 0) begin
      h = q.pop_front();
      exp_valid = 1;
      exp_en    = h.en;
      exp_d     = h.d;
      exp_m     = h.m;
      if (h.first) grp_pending--;
    end else begin
      exp_valid = 0;
      exp_en    = 0;
      exp_d     = '0;
      exp_m     = '0;
    end
    if (acc) begin
      case (freq_ratio_i)
        2'b00:   k = 1;
        2'b01:   k = 2;
        2'b10:   k = 4;
        default: begin k = 1; m_err = 1; end
      endcase
      for (int p = 0; p < k; p++) begin
        h.d     = wrdata_i[p*DW +: DW];
        h.m     = wrdata_mask_i[p*MW +: MW];
        h.en    = wrdata_en_i[p];
        h.first = (p == 0);
        q.push_back(h);
      end
      grp_pending++;
    end
  endtask

  // One clock: check ready before the edge, advance the model, check after.
  // Entered and left at a falling edge; inputs change only between steps.
  task automatic step();
    #1;
    check("ready", in_ready_o, m_ready());
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("out_valid", out_valid_o, exp_valid);
    check("wrdata_en", wrdata_en_o, exp_en);
    check("wrdata", wrdata_o, exp_d);
    check("wrdata_mask", wrdata_mask_o, exp_m);
    check("fifo_count", fifo_count_o, grp_pending);
    check("cfg_err", cfg_err_o, m_err);
  endtask

  task automatic rand_data();
    wrdata_i      = {$urandom, $urandom};
    wrdata_mask_i = PH*MW'($urandom);
    wrdata_en_i   = PH'($urandom);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    rst_i = 1'b1;
    #1;
    model_reset();
    check("rst_out_valid", out_valid_o, 0);
    check("rst_wrdata", wrdata_o, 0);
    check("rst_count", fifo_count_o, 0);
    check("rst_ready", in_ready_o, 0);
    check("rst_cfg_err", cfg_err_o, 0);
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] exp2 [4] = '{8'hA0, 8'hA1, 8'hB0, 8'hB1};
  logic [7:0] obs  [4];
  int         peak;
  int         accepted;
  int         nv;

  initial begin
    @(negedge clk);
    do_reset();
    enable_i = 1'b1;

    // 1:4 single group, lane0 0x11..0x44.
    freq_ratio_i  = 2'b10;
    wrdata_i      = 64'h0044_0033_0022_0011;
    wrdata_mask_i = 8'hE4;
    wrdata_en_i   = 4'b1111;
    in_valid_i    = 1'b1;
    step();
    in_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t1_valid", out_valid_o, 1);
      check("t1_lane0", wrdata_o[7:0], vals[i]);
    end
    step();
    check("t1_idle_valid", out_valid_o, 0);
    check("t1_idle_data", wrdata_o, 0);

    // 1:2, two groups back to back.
    do_reset();
    freq_ratio_i = 2'b01;
    wrdata_en_i  = 4'b0011;
    wrdata_i     = 64'h0000_0000_00A1_00A0;
    in_valid_i   = 1'b1;
    step();
    peak = int'(fifo_count_o);
    wrdata_i = 64'h0000_0000_00B1_00B0;
    for (int i = 0; i < 4; i++) begin
      step();
      in_valid_i = 1'b0;
      obs[i] = wrdata_o[7:0];
      if (int'(fifo_count_o) > peak) peak = int'(fifo_count_o);
    end
    for (int i = 0; i < 4; i++) check("t2_order", obs[i], exp2[i]);
    check("t2_peak_count", peak, 1);

    // 1:4 with valid held high: fill the FIFO and the serializer.
    do_reset();
    freq_ratio_i = 2'b10;
    in_valid_i   = 1'b1;
    rand_data();
    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!in_ready_o) break;
      accepted++;
      step();
      rand_data();
    end
    check("t3_accepted", accepted, 5);
    for (int i = 0; i < 30; i++) begin
      step();
      rand_data();
    end
    in_valid_i = 1'b0;
    for (int i = 0; i < 30; i++) step();

    // Reserved ratio: single phase and sticky error.
    do_reset();
    freq_ratio_i = 2'b11;
    wrdata_en_i  = 4'b1111;
    rand_data();
    in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      nv += int'(out_valid_o);
    end
    check("t4_phases", nv, 1);
    check("t4_err_set", cfg_err_o, 1);
    freq_ratio_i = 2'b01;
    rand_data();
    in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("t4_err_sticky", cfg_err_o, 1);
    do_reset();
    step();
    check("t4_err_cleared", cfg_err_o, 0);

    // enable_i low for 3 cycles where phase 1 would be emitted.
    do_reset();
    freq_ratio_i  = 2'b10;
    wrdata_en_i   = 4'b1111;
    wrdata_i      = 64'h0044_0033_0022_0011;
    in_valid_i    = 1'b1;
    step();
    rand_data();
    step();
    in_valid_i = 1'b0;
    check("t5_phase0", wrdata_o[7:0], vals[0]);
    enable_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_gap_valid", out_valid_o, 0);
      check("t5_gap_count", fifo_count_o, 1);
    end
    enable_i = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      check("t5_resume", wrdata_o[7:0], vals[i]);
    end
    for (int i = 0; i < 6; i++) step();

    // Asynchronous reset in the middle of a 1:4 group.
    do_reset();
    freq_ratio_i = 2'b10;
    wrdata_en_i  = 4'b1111;
    rand_data();
    in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    step();
    step();
    check("t6_mid_group", out_valid_o, 1);
    #2;
    do_reset();
    wrdata_i    = 64'h0044_0033_0022_0011;
    wrdata_en_i = 4'b1111;
    in_valid_i  = 1'b1;
    step();
    in_valid_i = 1'b0;
    step();
    check("t6_fresh_phase0", wrdata_o[7:0], vals[0]);
    for (int i = 0; i < 5; i++) step();

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      in_valid_i   = ($urandom_range(2) != 0);
      freq_ratio_i = ($urandom_range(15) == 0) ? 2'b11 : 2'($urandom_range(2));
      enable_i     = ($urandom_range(7) != 0);
      rand_data();
      step();
    end
    in_valid_i = 1'b0;
    enable_i   = 1'b1;
    for (int i = 0; i < 30; i++) step();
    check("final_drained", fifo_count_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/asu_ddr5_phase_serializer.md
Name: asu_ddr5_phase_serializer

Overview:
- Parametrised multi-lane DFI write-phase serializer.
- Accepts one multi-phase DFI write group per handshake, buffers groups in a FIFO, and emits one phase per clock, oldest phase first, across pNUM_LANE independent byte lanes.
- The phase count per group follows the DFI frequency ratio (1:1, 1:2 or 1:4), sampled per group.
- Sits between the DFI input interface and the write manager. It generalises the fixed 4-phase collapse into a buffered, back-pressured, multi-lane datapath.

Parameters:
- pDRAM_SIZE, 4, DRAM device width N. Per-lane phase data = 2N bits; per-lane phase mask = N/4 bits.
- pNUM_LANE, 2, number of lanes sharing one handshake and control.
- pNUM_PHASE, 4, maximum phases per group. Fixed at 4 for DFI.
- pDEPTH, 4, FIFO depth in groups. Power of two, ≥2.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- enable_i  in  1  block enable.
- freq_ratio_i  in  2  00=1:1, 01=1:2, 10=1:4, 11=reserved.
- in_valid_i  in  1  group valid.
- in_ready_o  out  1  group accepted when in_valid_i & in_ready_o at an edge.
- wrdata_en_i  in  pNUM_PHASE  per-phase write enable; bit k = phase k.
- wrdata_i  in  pNUM_PHASE*pNUM_LANE*2*pDRAM_SIZE  phase-major, then lane-major data.
- wrdata_mask_i  in  pNUM_PHASE*pNUM_LANE*pDRAM_SIZE/4  same packing as wrdata_i.
- out_valid_o  out  1  serialized phase valid.
- wrdata_en_o  out  1  write enable of the current phase.
- wrdata_o  out  pNUM_LANE*2*pDRAM_SIZE  current phase data.
- wrdata_mask_o  out  pNUM_LANE*pDRAM_SIZE/4  current phase mask.
- fifo_count_o  out  $clog2(pDEPTH)+1  occupied group entries.
- cfg_err_o  out  1  sticky reserved-ratio flag.

Behaviour:
- Reset (asynchronous, any time): FIFO pointers, count, phase counter, outputs and cfg_err_o all go to 0. in_ready_o is 0 while rst_i is high. Any in-flight group is discarded.
- in_ready_o = enable_i & ~rst_i & (fifo_count_o < pDEPTH).
  - Combinational, no full-bypass: a pop in the same cycle does not raise ready.
- Push: each entry stores all phases plus a phase count K sampled from freq_ratio_i at the push edge.
  - K = 1, 2 or 4. Reserved code 11 gives K=1 and sets cfg_err_o; it clears only on reset.
  - Phases ≥ K are dropped.
- Serializer states:
  - IDLE: no entry loaded.
  - SHIFT: phase counter 0..K-1 over the head entry.
- Latency: a push at edge E into an empty, idle block produces phase 0 registered on the outputs after edge E+1. Phase k follows after edge E+1+k.
- Back-to-back entries: the last phase of entry i is followed by phase 0 of entry i+1 on the next cycle, with no bubble.
  - The pop occurs at the edge that loads entry i+1 (or goes IDLE).
- Simultaneous push and pop: count unchanged.
- Push to empty while the serializer is on its last phase: the new entry is loaded with no gap.
- Idle outputs (IDLE or enable_i=0): out_valid_o=0, wrdata_en_o=0, wrdata_o=0, wrdata_mask_o=0, registered.
- out_valid_o=1 for every emitted phase, whatever its wrdata_en bit. wrdata_en_o carries the stored per-phase bit.
- enable_i low: no push, no pop, phase counter frozen, outputs idle from the next edge. When enable_i returns, output resumes at the frozen phase, one cycle later.
- freq_ratio_i changes affect only subsequent pushes; loaded entries keep their K.
- Sustained throughput: one phase per clock. At 1:4 the input accepts at most one group per 4 cycles at steady state.

Test Plan:
- Ratio 10, push one group with lane0 data phases 0x11,0x22,0x33,0x44 and en=1111 → out_valid high for 4 cycles starting 1 cycle after the push, data 0x11,0x22,0x33,0x44, then idle zeros.
- Ratio 01, push two groups back-to-back (A0,A1 then B0,B1) → A0,A1,B0,B1 on 4 consecutive cycles with no bubble; fifo_count_o peaks at 1.
- pDEPTH=4, ratio 10, in_valid held high → 5 groups accepted (4 buffered + 1 in serializer). in_ready_o then low until a pop; no group lost or duplicated; output order matches input order.
- Ratio 11 push → single phase emitted (phase 0 only), cfg_err_o=1 and still 1 after later valid-ratio traffic, cleared by rst_i.
- enable_i dropped for 3 cycles during phase 1 of a 1:4 group → outputs zero for those 3 cycles, then phases 1,2,3 emitted; fifo_count_o unchanged during the gap.
- rst_i asserted mid-group at 1:4 → all outputs 0 immediately (asynchronous) and fifo_count_o=0; after release a fresh push serializes correctly from phase 0.
